// File: rtl/dw_event_pkg.sv
// rtl/dw_event_pkg.sv - shared types, default sizes and pointer-width helper for the decision-wait event bridge
package dw_event_pkg;

   typedef enum logic {
      EVT_A = 1'b0,
      EVT_B = 1'b1
   } evt_src_e;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int DEPTH_DEF       = 4;

   // Index width for a DEPTH-entry ring; a single-entry ring still needs one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dw_sync_bit.sv
// rtl/dw_sync_bit.sv - multi-flop synchroniser for one asynchronous level, cleared by async reset
module dw_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/dw_event_bridge.sv
// rtl/dw_event_bridge.sv - 2-phase req/ack to clocked event FIFO bridge; EVT_TIMESTAMP_EN adds per-event timestamps
module dw_event_bridge
   import dw_event_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DEPTH       = DEPTH_DEF
`ifdef EVT_TIMESTAMP_EN
   , parameter int TS_W      = 16
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_a,
   input  logic                   req_b,
   output logic                   ack_a,
   output logic                   ack_b,
   output logic                   evt_valid,
   output logic                   evt_id,
   input  logic                   evt_ready,
`ifdef EVT_TIMESTAMP_EN
   output logic [TS_W-1:0]        evt_ts,
`endif
   output logic [$clog2(DEPTH):0] evt_count
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic             req_a_s;
   logic             req_b_s;
   logic             pend_a;
   logic             pend_b;
   logic             pop;
   logic             push_ok;
   logic             push;
   evt_src_e         grant_id;
   logic             rr_b;
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [DEPTH-1:0] id_mem;

   dw_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_a (
      .clk (clk),
      .rst (rst),
      .d   (req_a),
      .q   (req_a_s)
   );

   dw_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_b (
      .clk (clk),
      .rst (rst),
      .d   (req_b),
      .q   (req_b_s)
   );

   // A source is pending while its synchronised request differs from the ack we have returned.
   always_comb begin
      pend_a   = req_a_s ^ ack_a;
      pend_b   = req_b_s ^ ack_b;
      pop      = evt_valid & evt_ready;
      push_ok  = (evt_count < DEPTH_C) | pop;
      push     = 1'b0;
      grant_id = EVT_A;
      if (push_ok) begin
         if (pend_a && pend_b) begin
            push     = 1'b1;
            grant_id = rr_b ? EVT_B : EVT_A;
         end else if (pend_a) begin
            push     = 1'b1;
            grant_id = EVT_A;
         end else if (pend_b) begin
            push     = 1'b1;
            grant_id = EVT_B;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_a     <= 1'b0;
         ack_b     <= 1'b0;
         rr_b      <= 1'b0;
         wptr      <= '0;
         rptr      <= '0;
         id_mem    <= '0;
         evt_count <= '0;
      end else begin
         if (push) begin
            id_mem[wptr] <= grant_id;
            wptr         <= wptr + PTR_W'(1);
            if (grant_id == EVT_A) begin
               ack_a <= ~ack_a;
            end else begin
               ack_b <= ~ack_b;
            end
            if (pend_a && pend_b) begin
               rr_b <= ~rr_b;
            end
         end
         if (pop) begin
            rptr <= rptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   evt_count <= evt_count + CNT_W'(1);
            2'b01:   evt_count <= evt_count - CNT_W'(1);
            default: evt_count <= evt_count;
         endcase
      end
   end

   assign evt_valid = (evt_count != '0);
   assign evt_id    = evt_valid ? id_mem[rptr] : 1'b0;

`ifdef EVT_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;
   logic [TS_W-1:0] ts_mem [DEPTH];

   // Each entry captures the counter value present at its push edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ts_mem[i] <= '0;
         end
      end else begin
         ts_cnt <= ts_cnt + TS_W'(1);
         if (push) begin
            ts_mem[wptr] <= ts_cnt;
         end
      end
   end

   assign evt_ts = evt_valid ? ts_mem[rptr] : '0;
`endif

endmodule

// File: tb/tb_dw_event_bridge.sv
// tb/tb_dw_event_bridge.sv - self-checking bench for dw_event_bridge against a queue-based event model
module tb_dw_event_bridge;
   import dw_event_pkg::*;

   localparam int S = 2;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_a;
   logic       req_b;
   logic       ack_a;
   logic       ack_b;
   logic       evt_valid;
   logic       evt_id;
   logic       evt_ready;
   logic [2:0] evt_count;
`ifdef EVT_TIMESTAMP_EN
   logic [15:0] evt_ts;
   int          mts[$];
   int          ts_now;
`endif

   int total = 0;
   int bad   = 0;

   // Model: toggle counts per source, delayed visibility, FIFO of ids, round-robin flag.
   int tog_a, tog_b, acked_a, acked_b;
   int hist_a[$];
   int hist_b[$];
   int mq[$];
   bit rr_b;

   always #5 clk = ~clk;

   dw_event_bridge dut (
      .clk       (clk),
      .rst       (rst),
      .req_a     (req_a),
      .req_b     (req_b),
      .ack_a     (ack_a),
      .ack_b     (ack_b),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .evt_ready (evt_ready),
`ifdef EVT_TIMESTAMP_EN
      .evt_ts    (evt_ts),
`endif
      .evt_count (evt_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      tog_a = 0; tog_b = 0; acked_a = 0; acked_b = 0; rr_b = 1'b0;
      hist_a.delete(); hist_b.delete(); mq.delete();
      for (int i = 0; i < S; i++) begin
         hist_a.push_back(0);
         hist_b.push_back(0);
      end
`ifdef EVT_TIMESTAMP_EN
      mts.delete();
      ts_now = 0;
`endif
   endtask

   task automatic model_edge();
      int va, vb, win;
      bit pop, room, pa, pb;
      va = hist_a.pop_front(); hist_a.push_back(tog_a);
      vb = hist_b.pop_front(); hist_b.push_back(tog_b);
      pop  = (mq.size() > 0) && evt_ready;
      room = (mq.size() < D) || pop;
      pa = (va != acked_a);
      pb = (vb != acked_b);
      win = -1;
      if (room) begin
         if (pa && pb) begin
            win  = rr_b ? 1 : 0;
            rr_b = !rr_b;
         end else if (pa) begin
            win = 0;
         end else if (pb) begin
            win = 1;
         end
      end
      if (pop) begin
         void'(mq.pop_front());
`ifdef EVT_TIMESTAMP_EN
         void'(mts.pop_front());
`endif
      end
      if (win == 0) acked_a++;
      if (win == 1) acked_b++;
      if (win >= 0) begin
         mq.push_back(win);
`ifdef EVT_TIMESTAMP_EN
         mts.push_back(ts_now);
`endif
      end
`ifdef EVT_TIMESTAMP_EN
      ts_now = (ts_now + 1) % 65536;
`endif
   endtask

   task automatic check_all();
      chk("ack_a", ack_a, acked_a % 2);
      chk("ack_b", ack_b, acked_b % 2);
      chk("evt_valid", evt_valid, mq.size() > 0);
      chk("evt_count", evt_count, mq.size());
      if (mq.size() > 0) begin
         chk("evt_id", evt_id, mq[0]);
`ifdef EVT_TIMESTAMP_EN
         chk("evt_ts", evt_ts, mts[0]);
`endif
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic toggle(input bit src);
      if (!src) begin
         req_a = ~req_a; tog_a++;
      end else begin
         req_b = ~req_b; tog_b++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
      #1;
      chk("rst_ack_a", ack_a, 0);
      chk("rst_ack_b", ack_b, 0);
      chk("rst_evt_valid", evt_valid, 0);
      chk("rst_evt_id", evt_id, 0);
      chk("rst_evt_count", evt_count, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
   endtask

   task automatic drain(input int budget);
      bit idle;
      evt_ready = 1'b1;
      idle = 1'b0;
      for (int i = 0; i < budget; i++) begin
         idle = (mq.size() == 0) && (acked_a == tog_a) && (acked_b == tog_b);
         if (idle) break;
         tick();
      end
      idle = (mq.size() == 0) && (acked_a == tog_a) && (acked_b == tog_b);
      chk("drain_done", idle, 1);
   endtask

   initial begin
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; evt_ready = 1'b0;
      model_clear();
      do_reset();
      check_all();

      // single event: ack and valid exactly three edges after the toggle
      evt_ready = 1'b1;
      toggle(0);
      ticks(2);
      chk("single_ack_early", ack_a, 0);
      chk("single_valid_early", evt_valid, 0);
      tick();
      chk("single_ack", ack_a, 1);
      chk("single_valid", evt_valid, 1);
      chk("single_id", evt_id, 0);
      tick();
      chk("single_valid_gone", evt_valid, 0);
      ticks(2);

      // simultaneous pairs alternate winners
      toggle(0); toggle(1);
      ticks(3);
      chk("pair1_first", evt_id, 0);
      tick();
      chk("pair1_second", evt_id, 1);
      ticks(3);
      toggle(0); toggle(1);
      ticks(3);
      chk("pair2_first", evt_id, 1);
      tick();
      chk("pair2_second", evt_id, 0);
      ticks(3);

      // backpressure: six alternating events into a four-entry FIFO
      evt_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         toggle(i[0]);
         ticks(4);
      end
      chk("bp_count_full", evt_count, 4);
      chk("bp_fifth_unacked", ack_a ^ req_a, 1);
      drain(40);
      chk("bp_ack_a_final", ack_a, req_a);
      chk("bp_ack_b_final", ack_b, req_b);

      // full FIFO with simultaneous pop and push
      evt_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         toggle(i[0]);
         ticks(4);
      end
      toggle(1);
      ticks(4);
      chk("fp_count_before", evt_count, 4);
      chk("fp_b_pending", ack_b ^ req_b, 1);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      chk("fp_count_after", evt_count, 4);
      chk("fp_b_acked", ack_b ^ req_b, 0);
      ticks(2);
      drain(40);

      // reset with three queued and one in flight
      evt_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         toggle(i[0]);
         ticks(4);
      end
      toggle(1);
      tick();
      chk("mid_count_before", evt_count, 3);
      do_reset();
      evt_ready = 1'b1;
      ticks(10);
      chk("post_rst_no_evt", evt_valid, 0);

      // randomized traffic and readiness
      for (int i = 0; i < 600; i++) begin
         if (tog_a == acked_a && $urandom_range(3) == 0) toggle(0);
         if (tog_b == acked_b && $urandom_range(3) == 0) toggle(1);
         evt_ready = ($urandom_range(2) != 0);
         tick();
      end
      drain(60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
